tdp_ram_fifo_ctrl: RTL
======================

// Module: tdp_ram_fifo_ctrl
// PURPOSE
//   Sits upstream of and around tdp_ram, 64x8 dual-port RAM, and turns it into a synchronous FIFO.
//   Port A of the RAM is the write side and port B is the read side.
//   Takes a valid/ready byte stream in and delivers a valid/ready byte stream out.
//   Absorbs the RAM's 1-cycle registered read latency with a 2-entry output buffer.
// PARAMETERS
//   DATA_W  8   data width; matches the RAM word width
//   ADDR_W  6   RAM address width; DEPTH = 2**ADDR_W = 64
// PORTS
//   clk        in   1         single clock; all logic on posedge
//   sclr       in   1         reset: synchronous, active-low; also wired to the RAM sclr
//   in_data    in   DATA_W    write data
//   in_valid   in   1         write request
//   in_ready   out  1         write accepted when in_valid & in_ready
//   out_data   out  DATA_W    head-of-FIFO data; registered
//   out_valid  out  1         out_data holds a valid entry
//   out_ready  in   1         consumer pops when out_valid & out_ready
//   ram_words  out  ADDR_W+1  entries held in RAM, 0..64; excludes in-flight and output buffer
//   full       out  1         ram_words == DEPTH
//   empty      out  1         ram_words == 0 & no read in flight & output buffer empty
//   ram_din_a  out  DATA_W    = in_data
//   ram_addr_a out  ADDR_W    = wr_ptr
//   ram_we_a   out  1         active-low; 0 only on an accepted push
//   ram_din_b  out  DATA_W    tied 0
//   ram_addr_b out  ADDR_W    = rd_ptr
//   ram_we_b   out  1         tied 1 (port B is read-only)
//   ram_dout_b in   DATA_W    RAM port B read data; valid 1 cycle after the read is issued
// BEHAVIOUR
//   Reset (sclr==0 at posedge): wr_ptr=rd_ptr=0, ram_words=0, rd_inflight=0, buffer cleared.
//     Outputs after reset: out_valid=0, out_data=0, full=0, empty=1.
//     While sclr==0: in_ready=0 and ram_we_a=1 (combinational), so no write can reach the RAM.
//     RAM contents are not cleared. Reset mid-stream drops all queued and in-flight data.
//   Push = in_valid & in_ready, with in_ready = ~full & sclr.
//     No same-cycle push-through when full, even if a pop occurs in the same cycle.
//     On push: RAM is written at that edge; wr_ptr += 1 (wraps 63 -> 0); ram_words += 1.
//   Read issue rd_en = (ram_words != 0) & (obuf_cnt + rd_inflight - pop < 2).
//     On rd_en: rd_ptr += 1 (wraps 63 -> 0); ram_words -= 1; rd_inflight <= 1.
//     A push and a read issue in the same cycle leave ram_words unchanged.
//   Capture: when rd_inflight==1, ram_dout_b is written into the output buffer at the next edge.
//     The credit rule above guarantees the buffer never overflows.
//   Write/read hazard: an entry becomes readable only the cycle after its write edge.
//     So rd_ptr never reads a word being written in the same cycle.
//   Latency: push at edge E0 -> read issued in cycle after E0 -> captured at E2 -> out_valid=1 after E2.
//   Throughput: 1 word/cycle sustained in steady state with out_ready held high.
//   Output buffer: 2-entry FIFO, head drives out_data/out_valid.
//     Pop and capture in the same cycle are both honoured.
//     out_data holds its value while out_valid & ~out_ready.
//   Pointer width is ADDR_W; full and empty are resolved by ram_words, not by pointer compare.
// STRUCTURE
//   Package tdp_ram_pkg: DATA_W, ADDR_W, DEPTH, RAM_RD_LAT=1, RAM_WE_ACTIVE=1'b0.
//   Sub-module fifo_skid2: 2-entry output buffer (push/pop/cnt, sync active-low sclr).
//   Top level holds pointers, ram_words, rd_inflight, credit logic and the RAM port drive.
// TESTING (bench instantiates tdp_ram plus this block)
//   1. Reset: sclr=0 for 2 cycles -> out_valid=0, out_data=0, empty=1, full=0, in_ready=0, ram_we_a=1.
//   2. Single word: push 0xA5, out_ready=1 -> out_valid rises after 2nd edge past push, data 0xA5.
//      ram_words goes 0 -> 1 -> 0.
//   3. Fill: out_ready=0, push 66 words 0x00..0x41.
//      -> first 2 fill the buffer, then 64 fill the RAM, full=1, ram_words=64, in_ready=0.
//      Drain -> bytes 0x00..0x41 in order.
//   4. Wrap: stream 200 words with out_ready=1 and random in_valid.
//      -> order preserved across pointer wrap 63 -> 0, no loss, no duplicates.
//   5. Backpressure: random out_ready at ~50% while streaming.
//      -> out_data stable while stalled; buffer never exceeds 2; sequence intact.
//   6. Mid-stream reset: 10 words queued, sclr=0 for 1 cycle.
//      -> empty=1, out_valid=0 next cycle; next push 0x3C emerges first.

Source files
------------

// File: rtl/tdp_ram_pkg.sv
// Shared constants for the dual-port RAM and the FIFO controller wrapped around it.
//   DATA_W        RAM word width
//   ADDR_W        RAM address width
//   DEPTH         number of RAM words
//   RAM_RD_LAT    registered read latency of the RAM, in cycles
//   RAM_WE_ACTIVE level of we_a/we_b that performs a write
package tdp_ram_pkg;
  localparam int   DATA_W        = 8;
  localparam int   ADDR_W        = 6;
  localparam int   DEPTH         = 1 << ADDR_W;
  localparam int   RAM_RD_LAT    = 1;
  localparam logic RAM_WE_ACTIVE = 1'b0;
endpackage

// File: rtl/fifo_skid2.sv
// Two-entry FIFO that holds words returned by the RAM until the consumer takes them.
// The head entry is a register and drives dout directly.
// Ports:
//   clk    clock
//   sclr   synchronous active-low clear
//   push   write din this cycle (caller guarantees space, or a same-cycle pop)
//   din    data to write
//   pop    remove the head this cycle (caller guarantees valid)
//   dout   head entry
//   valid  head entry is valid
//   cnt    number of entries held, 0..2
module fifo_skid2 #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          sclr,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          valid,
  output logic [1:0]    cnt
);
  logic [DW-1:0] e0;  // head
  logic [DW-1:0] e1;  // second entry

  always_ff @(posedge clk) begin
    if (!sclr) begin
      e0  <= '0;
      e1  <= '0;
      cnt <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) e0 <= din;
          else             e1 <= din;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          e0  <= e1;
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          // Count is unchanged; with one entry the new word becomes the head,
          // with two the second entry moves up and the new word takes its place.
          if (cnt == 2'd1) begin
            e0 <= din;
          end else begin
            e0 <= e1;
            e1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout  = e0;
  assign valid = (cnt != 2'd0);
endmodule

// File: rtl/tdp_ram.sv
// True dual-port RAM, DEPTH x DATA_W, with a registered read on both ports.
// Ports:
//   clk            clock
//   sclr           synchronous active-low clear of the read registers (contents kept)
//   din_a/addr_a   port A write data / address
//   we_a           port A write enable, active at RAM_WE_ACTIVE
//   dout_a         port A read data, one cycle after the address
//   din_b/addr_b   port B write data / address
//   we_b           port B write enable, active at RAM_WE_ACTIVE
//   dout_b         port B read data, one cycle after the address
module tdp_ram
  import tdp_ram_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = ADDR_W
) (
  input  logic          clk,
  input  logic          sclr,
  input  logic [DW-1:0] din_a,
  input  logic [AW-1:0] addr_a,
  input  logic          we_a,
  output logic [DW-1:0] dout_a,
  input  logic [DW-1:0] din_b,
  input  logic [AW-1:0] addr_b,
  input  logic          we_b,
  output logic [DW-1:0] dout_b
);
  logic [DW-1:0] mem [1<<AW];

  always_ff @(posedge clk) begin
    if (we_a == RAM_WE_ACTIVE) mem[addr_a] <= din_a;
    if (we_b == RAM_WE_ACTIVE) mem[addr_b] <= din_b;
  end

  always_ff @(posedge clk) begin
    if (!sclr) begin
      dout_a <= '0;
      dout_b <= '0;
    end else begin
      dout_a <= mem[addr_a];
      dout_b <= mem[addr_b];
    end
  end
endmodule

// File: rtl/tdp_ram_fifo_ctrl.sv
// Turns a 64x8 dual-port RAM into a synchronous FIFO. Port A writes, port B reads.
// A 2-entry output buffer absorbs the RAM's registered read latency so the
// output side streams one word per cycle.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high; valid never depends on ready, and ready never depends on valid.
//
// Ports:
//   clk         clock
//   sclr        synchronous active-low reset (also drives the RAM clear)
//   in_data     write data
//   in_valid    write request
//   in_ready    controller can take a word (not full, not in reset)
//   out_data    head-of-FIFO data, registered
//   out_valid   out_data is valid
//   out_ready   consumer takes the head word
//   ram_words   words held in RAM, excluding in-flight reads and the output buffer
//   full        RAM holds DEPTH words
//   empty       nothing stored anywhere
//   ram_*_a     RAM port A drive (write side)
//   ram_*_b     RAM port B drive (read side), ram_dout_b returns read data
module tdp_ram_fifo_ctrl
  import tdp_ram_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = ADDR_W
) (
  input  logic          clk,
  input  logic          sclr,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW:0]   ram_words,
  output logic          full,
  output logic          empty,
  output logic [DW-1:0] ram_din_a,
  output logic [AW-1:0] ram_addr_a,
  output logic          ram_we_a,
  output logic [DW-1:0] ram_din_b,
  output logic [AW-1:0] ram_addr_b,
  output logic          ram_we_b,
  input  logic [DW-1:0] ram_dout_b
);
  localparam logic [AW:0] FULL_CNT = AW'(1) << AW;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          rd_inflight;
  logic [1:0]    obuf_cnt;
  logic          push;
  logic          pop;
  logic          rd_en;
  logic [2:0]    credit_used;

  assign full     = (ram_words == FULL_CNT);
  assign in_ready = ~full & sclr;
  assign push     = in_valid & in_ready;
  assign pop      = out_valid & out_ready;

  // Slots the output buffer will occupy after this edge if no new read is issued.
  // A pop always has an entry behind it, so the subtraction cannot wrap.
  assign credit_used = {1'b0, obuf_cnt} + {2'b0, rd_inflight} - {2'b0, pop};
  // ram_words only counts words whose write edge has passed, so a word being
  // written this cycle is never the one read.
  assign rd_en = sclr & (ram_words != '0) & (credit_used < 3'd2);

  always_ff @(posedge clk) begin
    if (!sclr) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ram_words   <= '0;
      rd_inflight <= 1'b0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({push, rd_en})
        2'b10:   ram_words <= ram_words + (AW+1)'(1);
        2'b01:   ram_words <= ram_words - (AW+1)'(1);
        default: ;
      endcase
      rd_inflight <= rd_en;
    end
  end

  fifo_skid2 #(.DW(DW)) u_obuf (
    .clk   (clk),
    .sclr  (sclr),
    .push  (rd_inflight),
    .din   (ram_dout_b),
    .pop   (pop),
    .dout  (out_data),
    .valid (out_valid),
    .cnt   (obuf_cnt)
  );

  assign empty = (ram_words == '0) & ~rd_inflight & (obuf_cnt == 2'd0);

  assign ram_din_a  = in_data;
  assign ram_addr_a = wr_ptr;
  assign ram_we_a   = push ? RAM_WE_ACTIVE : ~RAM_WE_ACTIVE;
  assign ram_din_b  = '0;
  assign ram_addr_b = rd_ptr;
  assign ram_we_b   = ~RAM_WE_ACTIVE;
endmodule
